// File: rtl/seq_mag_cmp_pkg.sv
// Shared types for the chunk-serial magnitude comparator: FSM states and
// the 3-bit {gt,eq,lt} result encoding with the cascade resolution rule.
package seq_mag_cmp_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  typedef logic [2:0] res_t;  // {gt, eq, lt}

  localparam res_t RES_GT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_LT   = 3'b001;
  localparam res_t RES_NONE = 3'b000;

  // With eq clear, each output is the inverse of the opposite input; this
  // gives the (1,0,1) and (0,0,0) results for the degenerate cascades.
  function automatic res_t cascade_res(input logic gt, input logic eq, input logic lt);
    if (eq) return RES_EQ;
    return {~lt, 1'b0, ~gt};
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare; sgn selects two's-complement.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             sgn,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] xb, yb;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    xb = x;
    yb = y;
    if (sgn) begin
      xb[CHUNK-1] = ~x[CHUNK-1];
      yb[CHUNK-1] = ~y[CHUNK-1];
    end
  end

  assign gt = (xb > yb);
  assign eq = (xb == yb);
  assign lt = (xb < yb);

endmodule

// File: rtl/seq_mag_cmp.sv
// Sequential magnitude comparator: walks operands CHUNK bits per cycle from
// the MSB end, stops at the first differing chunk, else resolves via cascade.
module seq_mag_cmp
  import seq_mag_cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  input  logic                              i_gt,
  input  logic                              i_eq,
  input  logic                              i_lt,
  output logic                              busy,
  output logic                              done,
  output logic                              q_gt,
  output logic                              q_eq,
  output logic                              q_lt,
  output logic [$clog2(WIDTH/CHUNK):0]      n_used
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NW     = $clog2(NCHUNK) + 1;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             c_gt_r, c_eq_r, c_lt_r;

  logic             load, step, publish;
  res_t             res_nxt;
  logic [NW-1:0]    n_nxt;

  logic [CHUNK-1:0] ca, cb;
  logic             top_sgn;
  logic             k_gt, k_eq, k_lt;

  assign ca      = a_r[idx*CHUNK +: CHUNK];
  assign cb      = b_r[idx*CHUNK +: CHUNK];
  // Only the most significant chunk carries the sign.
  assign top_sgn = (SIGNED != 0) && (idx == IW'(NCHUNK - 1));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x   (ca),
    .y   (cb),
    .sgn (top_sgn),
    .gt  (k_gt),
    .eq  (k_eq),
    .lt  (k_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    publish   = 1'b0;
    res_nxt   = RES_NONE;
    n_nxt     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        if (!k_eq) begin
          publish   = 1'b1;
          res_nxt   = {k_gt, 1'b0, k_lt};
          n_nxt     = NW'(NCHUNK - int'(idx));
          state_nxt = DONE;
        end else if (idx != '0) begin
          step = 1'b1;
        end else begin
          publish   = 1'b1;
          res_nxt   = cascade_res(c_gt_r, c_eq_r, c_lt_r);
          n_nxt     = NW'(NCHUNK);
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      c_gt_r <= 1'b0;
      c_eq_r <= 1'b0;
      c_lt_r <= 1'b0;
      q_gt   <= 1'b0;
      q_eq   <= 1'b0;
      q_lt   <= 1'b0;
      n_used <= '0;
    end else begin
      if (load) begin
        a_r    <= a;
        b_r    <= b;
        c_gt_r <= i_gt;
        c_eq_r <= i_eq;
        c_lt_r <= i_lt;
        idx    <= IW'(NCHUNK - 1);
      end else if (step) begin
        idx <= idx - 1'b1;
      end
      if (publish) begin
        {q_gt, q_eq, q_lt} <= res_nxt;
        n_used             <= n_nxt;
      end
    end
  end

  assign busy = (state == CMP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Scoreboard bench: unsigned and signed comparators share stimulus; a
// whole-value reference model predicts result, chunk count and done cycle.
module tb_seq_mag_cmp;

  typedef struct {
    logic [2:0] res;
    int         n;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        i_gt = 1'b0, i_eq = 1'b0, i_lt = 1'b0;

  logic       busy0, done0, gt0, eq0, lt0;
  logic       busy1, done1, gt1, eq1, lt1;
  logic [2:0] n0, n1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  seq_mag_cmp #(.WIDTH(16), .CHUNK(4), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .i_gt(i_gt), .i_eq(i_eq), .i_lt(i_lt),
    .busy(busy0), .done(done0), .q_gt(gt0), .q_eq(eq0), .q_lt(lt0), .n_used(n0)
  );

  seq_mag_cmp #(.WIDTH(16), .CHUNK(4), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .i_gt(i_gt), .i_eq(i_eq), .i_lt(i_lt),
    .busy(busy1), .done(done1), .q_gt(gt1), .q_eq(eq1), .q_lt(lt1), .n_used(n1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: first differing chunk is the one holding the highest
  // differing bit; the ordering itself is a plain whole-word compare.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic [2:0] casc, input bit sgn);
    exp_t e;
    int   h;
    logic g;
    logic [15:0] d;
    e.due = 0;
    if (ma == mb) begin
      e.n = 4;
      if (casc[1]) e.res = 3'b010;
      else begin
        case ({casc[2], casc[0]})
          2'b10:   e.res = 3'b100;
          2'b01:   e.res = 3'b001;
          2'b00:   e.res = 3'b101;
          default: e.res = 3'b000;
        endcase
      end
    end else begin
      d = ma ^ mb;
      h = 0;
      for (int i = 0; i < 16; i++) if (d[i]) h = i;
      e.n = 4 - h / 4;
      g = sgn ? ($signed(ma) > $signed(mb)) : (ma > mb);
      e.res = {g, 1'b0, ~g};
    end
    return e;
  endfunction

  // Called at a negedge while both DUTs are idle; returns in the next idle cycle.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] tc);
    exp_t e0, e1;
    int nmax;
    a = ta; b = tb; {i_gt, i_eq, i_lt} = tc;
    start = 1'b1;
    e0 = model(ta, tb, tc, 1'b0);
    e1 = model(ta, tb, tc, 1'b1);
    e0.due = cyc + 1 + e0.n;
    e1.due = cyc + 1 + e1.n;
    q0.push_back(e0);
    q1.push_back(e1);
    nmax = (e0.n > e1.n) ? e0.n : e1.n;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); {i_gt, i_eq, i_lt} = 3'($urandom);
    repeat (nmax + 1) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " busy0"}, int'(busy0), 0);
    check({tag, " done0"}, int'(done0), 0);
    check({tag, " q0"}, int'({gt0, eq0, lt0}), 0);
    check({tag, " n0"}, int'(n0), 0);
    check({tag, " busy1"}, int'(busy1), 0);
    check({tag, " done1"}, int'(done1), 0);
    check({tag, " q1"}, int'({gt1, eq1, lt1}), 0);
    check({tag, " n1"}, int'(n1), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q0.size() > 0 && cyc > q0[0].due) begin
        check("uns late done", cyc, q0[0].due);
        void'(q0.pop_front());
      end
      if (q1.size() > 0 && cyc > q1[0].due) begin
        check("sgn late done", cyc, q1[0].due);
        void'(q1.pop_front());
      end
      if (done0) begin
        if (q0.size() == 0) check("uns spurious done", 1, 0);
        else begin
          e = q0.pop_front();
          check("uns result", int'({gt0, eq0, lt0}), int'(e.res));
          check("uns n_used", int'(n0), e.n);
          check("uns done cycle", cyc, e.due);
        end
      end
      if (done1) begin
        if (q1.size() == 0) check("sgn spurious done", 1, 0);
        else begin
          e = q1.pop_front();
          check("sgn result", int'({gt1, eq1, lt1}), int'(e.res));
          check("sgn n_used", int'(n1), e.n);
          check("sgn done cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [2:0] cas [5];
    int k;
    cas[0] = 3'b010; cas[1] = 3'b100; cas[2] = 3'b001; cas[3] = 3'b000; cas[4] = 3'b101;

    #1 chk_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h8123, 16'h7FFF, 3'b010);
    issue(16'h1234, 16'h1235, 3'b010);
    for (int i = 0; i < 5; i++) issue(16'hBEEF, 16'hBEEF, cas[i]);

    // Reset in the second CMP cycle must abort silently.
    a = 16'h0000; b = 16'h0000; {i_gt, i_eq, i_lt} = 3'b010;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 chk_zero("midreset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    issue(16'h0001, 16'h0000, 3'b010);

    // start held high across two compares.
    a = 16'h1234; b = 16'h1235; {i_gt, i_eq, i_lt} = 3'b010;
    start = 1'b1;
    k = cyc;
    q0.push_back('{res: 3'b001, n: 4, due: k + 5});
    q1.push_back('{res: 3'b001, n: 4, due: k + 5});
    q0.push_back('{res: 3'b001, n: 4, due: k + 11});
    q1.push_back('{res: 3'b001, n: 4, due: k + 11});
    while (cyc < k + 8) @(negedge clk);
    start = 1'b0;
    while (cyc < k + 12) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        2:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
        default: rb = ra ^ (16'($urandom) & 16'h00FF);
      endcase
      issue(ra, rb, 3'($urandom));
    end

    repeat (5) @(negedge clk);
    check("uns queue drained", q0.size(), 0);
    check("sgn queue drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mag_cmp.md
SEQ_MAG_CMP -- requirements
Module: seq_mag_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits compared per cycle; WIDTH is a multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have parameter SIGNED, default 0: 1 = two's-complement compare, 0 = unsigned.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port start  input  1  request a compare; sampled only in IDLE.
REQ-008 SHALL have ports a, b  input  WIDTH  operands; sampled on the accepted start edge.
REQ-009 SHALL have ports i_gt, i_eq, i_lt  input  1 each  cascade inputs from a lower-order stage; sampled with a and b.
REQ-010 SHALL have port busy  output  1  high in CMP state.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a result is published.
REQ-012 SHALL have ports q_gt, q_eq, q_lt  output  1 each  registered result.
REQ-013 SHALL have port n_used  output  clog2(NCHUNK)+1  number of chunks examined for the last result.

Function
REQ-014 SHALL implement FSM states IDLE, CMP and DONE.
REQ-015 In IDLE, start=1 SHALL latch a, b and the cascade inputs, set idx = NCHUNK-1, and enter CMP; start=0 SHALL leave the FSM in IDLE.
REQ-016 CMP SHALL compare chunk idx of the latched operands (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) in one cycle.
REQ-017 When SIGNED=1, CMP SHALL treat only the top chunk (idx = NCHUNK-1) as signed; all lower chunks are unsigned.
REQ-018 On a chunk mismatch, CMP SHALL register q_gt/q_lt (q_eq=0), set n_used = NCHUNK-idx, and go to DONE (early termination).
REQ-019 On an equal chunk with idx>0, CMP SHALL decrement idx and stay in CMP.
REQ-020 On an equal chunk with idx=0, CMP SHALL resolve from the cascade inputs and go to DONE; n_used = NCHUNK.
REQ-021 Cascade resolution SHALL be: i_eq=1 -> (0,1,0); else (i_gt,i_lt)=(1,0) -> (1,0,0); (0,1) -> (0,0,1); (0,0) -> (1,0,1); (1,1) -> (0,0,0), shown as (q_gt,q_eq,q_lt).
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 Latency: if start is accepted at edge E, done SHALL be high in the cycle after edge E+N, where N = n_used (1..NCHUNK).
REQ-024 q_* and n_used SHALL hold their values until the next result is published.
REQ-025 start while busy or in DONE SHALL be ignored; it is not queued.
REQ-026 start in the same cycle done is high SHALL be ignored; it is accepted only in IDLE.
REQ-027 Changes on a, b and i_* after acceptance SHALL NOT affect the current compare.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE and busy=0, done=0, q_gt=0, q_eq=0, q_lt=0, n_used=0, idx=0.
REQ-029 Reset during CMP SHALL abort the compare with no done pulse; the first start after rst deasserts SHALL be serviced normally.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the 3-bit result encoding {gt,eq,lt}.
REQ-031 The design SHALL instantiate one sub-module, chunk_cmp: a combinational CHUNK-bit compare with a signed-mode input, producing gt/eq/lt.
REQ-032 The design SHALL contain no other hierarchy.

Verification (WIDTH=16, CHUNK=4)
REQ-033 a=0x8123, b=0x7FFF, SIGNED=0 -> done in the cycle after edge E+1; q_gt=1; n_used=1.
REQ-034 The same operands with SIGNED=1 -> q_lt=1; n_used=1.
REQ-035 a=0x1234, b=0x1235 -> q_lt=1; n_used=4; done in the cycle after edge E+4.
REQ-036 a=b=0xBEEF with cascade (0,1,0), (1,0,0), (0,0,1), (0,0,0) and (1,0,1) -> (0,1,0), (1,0,0), (0,0,1), (1,0,1) and (0,0,0) respectively.
REQ-037 rst pulse in the 2nd CMP cycle of a=b=0x0000 -> no done pulse; all outputs 0; a following start with a=0x0001, b=0x0000 -> q_gt=1, n_used=4.
REQ-038 start held high continuously over two back-to-back compares -> exactly one done per compare, with an IDLE cycle between them.
